// File: rtl/ahb_write_beat_assembler.sv
// Purpose    : AHB-Lite slave write front end; packs four 32-bit word-write beats into one
//              128-bit word tagged with its register region (HADDR[5:4]).
// Latency    : word is valid the cycle after its 4th data phase completes; zero wait states otherwise.
// Backpressure: only a word-completing beat stalls (HREADYOUT=0) while the output word is unaccepted.
//
// Ports:
//   HCLK, HRESETn             clock, synchronous active-low reset
//   HSEL, HADDR, HWRITE,      AHB-Lite address phase
//   HTRANS, HSIZE, HREADY
//   HWDATA                    AHB-Lite data phase write data
//   HREADYOUT, HRESP          slave response (wait state / ERROR)
//   swdata, swdata_region     assembled word (beat k at [32k+31:32k]) and its region
//   swdata_valid, swdata_ready  valid/ready handshake to the slave write stage
module ahb_write_beat_assembler #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic                     HWRITE,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic                     HREADY,
  input  logic [DATA_W-1:0]        HWDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [DATA_W*BEATS-1:0]  swdata,
  output logic [1:0]               swdata_region,
  output logic                     swdata_valid,
  input  logic                     swdata_ready
);

  localparam int WORD_W = DATA_W * BEATS;
  localparam int ASM_W  = WORD_W - DATA_W;        // the last beat goes straight to the output register
  localparam int LANE_W = $clog2(BEATS);
  localparam int LANE_LO = 2;                     // byte offset bits of a word address
  localparam int REG_LO  = LANE_LO + LANE_W;      // region bits sit directly above the lane bits
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS - 1);
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no data phase pending
    ST_DATA = 2'd1,   // data phase of an accepted write
    ST_ERR1 = 2'd2,   // first ERROR cycle (wait)
    ST_ERR2 = 2'd3    // second ERROR cycle (ready)
  } state_t;

  state_t state_q, state_d;

  // Address-phase information carried into the data phase.
  logic [LANE_W-1:0] lat_lane;
  logic [1:0]        lat_region;
  logic [2:0]        lat_size;
  logic              lat_misalign;

  // Assembly of the first BEATS-1 beats, kept apart from the output register so
  // that these beats never have to wait for the downstream stage.
  logic [ASM_W-1:0]  asm_data;
  logic [1:0]        asm_region;
  logic [LANE_W-1:0] beat_cnt;

  logic addr_acc;
  logic addr_take;
  logic beat_legal;
  logic last_beat;
  logic slot_free;
  logic stall;
  logic beat_done;

  // High address bits and HTRANS[0] do not affect a write beat.
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:REG_LO+2], HTRANS[0]};

  // ------------------------------------------------------------------
  // Transfer qualification
  // ------------------------------------------------------------------
  assign addr_acc = HSEL & HREADY & HWRITE & HTRANS[1];

  // Beat 0 fixes the region; later beats must match it and arrive in lane order,
  // so an out-of-order wrapping burst is rejected here as well.
  assign beat_legal = (lat_size == SIZE_WORD) && !lat_misalign &&
                      (lat_lane == beat_cnt) &&
                      ((beat_cnt == '0) || (lat_region == asm_region));

  assign last_beat = (beat_cnt == LAST_LANE);

  // The output slot can take a new word if it is empty or is being consumed now.
  assign slot_free = !swdata_valid || swdata_ready;

  assign stall     = (state_q == ST_DATA) && beat_legal && last_beat && !slot_free;
  assign beat_done = (state_q == ST_DATA) && beat_legal && !stall;

  // A new address phase is only taken when no data phase is still being held;
  // an address phase shown during the error response is cancelled by the master.
  assign addr_take = addr_acc && ((state_q == ST_IDLE) || beat_done);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (addr_take) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!beat_legal) begin
          state_d = ST_ERR1;
        end else if (stall) begin
          state_d = ST_DATA;
        end else if (addr_take) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: bus response
  // An illegal beat is first held with one OKAY wait state (the data phase
  // has not finished yet), then gets the two-cycle ERROR response.
  // ------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
      ST_DATA: begin
        HREADYOUT = beat_done;
        HRESP     = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Address latch, assembly and output word
  // ------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      lat_lane      <= '0;
      lat_region    <= '0;
      lat_size      <= '0;
      lat_misalign  <= 1'b0;
      asm_data      <= '0;
      asm_region    <= '0;
      beat_cnt      <= '0;
      swdata        <= '0;
      swdata_region <= '0;
      swdata_valid  <= 1'b0;
    end else begin
      if (addr_take) begin
        lat_lane     <= HADDR[LANE_LO +: LANE_W];
        lat_region   <= HADDR[REG_LO +: 2];
        lat_size     <= HSIZE;
        lat_misalign <= |HADDR[1:0];
      end

      // Error drops any partial word; stale lanes are overwritten by the next word.
      if (state_q == ST_ERR1) begin
        beat_cnt <= '0;
      end

      if (beat_done && !last_beat) begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_cnt == LANE_W'(k)) begin
            asm_data[k*DATA_W +: DATA_W] <= HWDATA;
          end
        end
        if (beat_cnt == '0) begin
          asm_region <= lat_region;
        end
        beat_cnt <= beat_cnt + LANE_W'(1);
      end

      // A completing beat replaces the output word; this also covers the
      // back-to-back case where the old word is consumed in the same cycle.
      if (beat_done && last_beat) begin
        swdata        <= {HWDATA, asm_data};
        swdata_region <= asm_region;
        swdata_valid  <= 1'b1;
        beat_cnt      <= '0;
      end else if (swdata_valid && swdata_ready) begin
        swdata_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_write_beat_assembler.sv
// Purpose    : self-checking bench for ahb_write_beat_assembler with a pipelined AHB master
//              and a scoreboard of expected words.
// Latency    : words are compared whenever swdata_valid is high and popped on acceptance.
// Backpressure: downstream ready is held low for ds_delay cycles after each new word.
module tb_ahb_write_beat_assembler;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSEL;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic         HREADY;
  logic [31:0]  HWDATA;
  logic         HREADYOUT;
  logic         HRESP;
  logic [127:0] swdata;
  logic [1:0]   swdata_region;
  logic         swdata_valid;
  logic         swdata_ready = 1'b0;

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: bus-level ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahb_write_beat_assembler dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HSEL          (HSEL),
    .HADDR         (HADDR),
    .HWRITE        (HWRITE),
    .HTRANS        (HTRANS),
    .HSIZE         (HSIZE),
    .HREADY        (HREADY),
    .HWDATA        (HWDATA),
    .HREADYOUT     (HREADYOUT),
    .HRESP         (HRESP),
    .swdata        (swdata),
    .swdata_region (swdata_region),
    .swdata_valid  (swdata_valid),
    .swdata_ready  (swdata_ready)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic [1:0]   region;
    logic [127:0] data;
  } word_t;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  xfer_t aq[$];
  word_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int ds_delay = 0;
  int vcnt = 0;
  int waits, errs;
  logic [3:0] err_rdy;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] tr, input logic [2:0] sz);
    aq.push_back('{1'b1, tr, 1'b1, sz, a, d});
  endtask

  task automatic add_oth(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
    aq.push_back('{sel, tr, wr, 3'b010, a, $urandom});
  endtask

  // Queue a legal four-beat word at base and push its expected result.
  task automatic add_word(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    add_wr(base,        d0, T_NSEQ, 3'b010);
    add_wr(base + 32'h4, d1, T_SEQ, 3'b010);
    add_wr(base + 32'h8, d2, T_SEQ, 3'b010);
    add_wr(base + 32'hC, d3, T_SEQ, 3'b010);
    exp_q.push_back({base[5:4], d3, d2, d1, d0});
  endtask

  // Pipelined master: drives address phase of aq[0] and data of the previous
  // accepted transfer; both advance only when HREADYOUT is high.
  task automatic run_bus(input int max_cyc);
    logic        dp_act = 1'b0;
    logic [31:0] dp_data = '0;
    bit          idle_next = 1'b0;
    bit          drove;
    int          cyc = 0;
    xfer_t       x;
    waits = 0; errs = 0; err_rdy = '0;
    while ((aq.size() > 0 || dp_act) && cyc < max_cyc) begin
      @(posedge HCLK); #1;
      drove = (aq.size() > 0) && !idle_next;
      if (drove) begin
        x = aq[0];
        HSEL = x.sel; HTRANS = x.trans; HWRITE = x.wr; HSIZE = x.size; HADDR = x.addr;
      end else begin
        HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = '0;
      end
      HWDATA = dp_act ? dp_data : 32'hDEAD_BEEF;
      idle_next = 1'b0;
      @(negedge HCLK);
      cyc++;
      if (!HREADYOUT) waits++;
      if (HRESP) begin
        errs++;
        err_rdy = {err_rdy[2:0], HREADYOUT};
      end
      if (HREADYOUT) begin
        dp_act = 1'b0;
        if (drove) begin
          x = aq.pop_front();
          if (x.trans[1]) begin
            dp_act  = 1'b1;
            dp_data = x.wr ? x.data : $urandom;
          end
        end
      end else if (HRESP) begin
        idle_next = 1'b1;   // cancel the next transfer during the ERROR response
      end
    end
    chk("bus_done", {30'd0, aq.size() != 0, dp_act}, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge HCLK);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hreadyout"}, HREADYOUT, 1);
    chk({tag, "_hresp"}, HRESP, 0);
    chk({tag, "_swdata"}, swdata, 0);
    chk({tag, "_region"}, swdata_region, 0);
    chk({tag, "_valid"}, swdata_valid, 0);
  endtask

  // Scoreboard monitor: any valid word must equal the queue head (this also
  // checks the held word stays stable); acceptance pops it.
  always @(negedge HCLK) begin
    if (HRESETn && swdata_valid) begin
      chk("valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("word", {swdata_region, swdata}, exp_q[0]);
      if (swdata_ready) begin
        if (exp_q.size() > 0) exp_q.pop_front();
        vcnt = 0;
      end else begin
        vcnt++;
      end
    end else begin
      vcnt = 0;
    end
  end

  // Downstream: ready rises once a word has been valid for ds_delay cycles.
  initial begin
    forever begin
      @(posedge HCLK); #1;
      swdata_ready = (vcnt >= ds_delay);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = T_IDLE;
    HSIZE = 3'b010; HWDATA = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_reset("rst0");
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // INCR4 @0x10, always-ready downstream: region 1, no wait states, valid one cycle later.
    add_word(32'h10, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    run_bus(40);
    @(negedge HCLK);
    chk("t2_latency", swdata_valid, 1);
    chk("t2_waits", waits, 0);
    chk("t2_errs", errs, 0);
    drain();

    // Back-to-back words @0x30. Word 1's last beat is at cycle 4 so it is valid
    // at cycle 5; ready comes 6 cycles later (cycle 11). Word 2's last beat is
    // presented at cycle 8 and waits through cycles 8,9,10: three wait states.
    ds_delay = 6;
    add_word(32'h30, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    add_word(32'h30, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
    run_bus(60);
    chk("t3_waits", waits, 3);
    chk("t3_errs", errs, 0);
    drain();

    // Held word plus a partial word, then reset: both discarded, next word starts at lane 0.
    ds_delay = 100;
    add_word(32'h00, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    add_wr(32'h00, 32'hCC00_0000, T_NSEQ, 3'b010);
    add_wr(32'h04, 32'hCC00_0001, T_SEQ, 3'b010);
    run_bus(40);
    chk("t1_partial_waits", waits, 0);
    @(posedge HCLK); #1 HRESETn = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_reset("rst1");
    @(posedge HCLK); #1 HRESETn = 1'b1;
    ds_delay = 0;
    add_word(32'h00, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003);
    run_bus(40);
    chk("t1_errs", errs, 0);
    drain();

    // Halfword write: two ERROR cycles, ready low then high, no word.
    add_wr(32'h00, 32'h5555_5555, T_NSEQ, 3'b001);
    run_bus(40);
    chk("t4_errs", errs, 2);
    chk("t4_err_rdy", err_rdy, 4'b0001);
    repeat (3) @(posedge HCLK);
    chk("t4_no_word", swdata_valid, 0);

    // Region change on the third beat: ERROR, then a clean word @0x20 (region 2).
    add_wr(32'h00, 32'hE000_0000, T_NSEQ, 3'b010);
    add_wr(32'h04, 32'hE000_0001, T_SEQ, 3'b010);
    add_wr(32'h14, 32'hE000_0002, T_SEQ, 3'b010);
    run_bus(40);
    chk("t5_errs", errs, 2);
    chk("t5_err_rdy", err_rdy, 4'b0001);
    add_word(32'h20, 32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003);
    run_bus(40);
    chk("t5_errs_after", errs, 0);
    chk("t5_waits_after", waits, 0);
    drain();

    // Word @0x00 with IDLE, read, unselected write and BUSY traffic interleaved.
    add_wr(32'h00, 32'h7000_0000, T_NSEQ, 3'b010);
    add_oth(1'b1, T_IDLE, 1'b1, 32'h04);
    add_wr(32'h04, 32'h7000_0001, T_NSEQ, 3'b010);
    add_oth(1'b1, T_NSEQ, 1'b0, 32'h48);
    add_oth(1'b0, T_NSEQ, 1'b1, 32'h08);
    add_oth(1'b1, T_BUSY, 1'b1, 32'h08);
    add_wr(32'h08, 32'h7000_0002, T_SEQ, 3'b010);
    add_wr(32'h0C, 32'h7000_0003, T_SEQ, 3'b010);
    exp_q.push_back({2'd0, 32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_0000});
    run_bus(60);
    chk("t6_errs", errs, 0);
    chk("t6_waits", waits, 0);
    drain();

    repeat (4) @(posedge HCLK);
    chk("final_idle_valid", swdata_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
